moore_seq_detector: RTL and testbench
=====================================

MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 Parameter PAT_W, default 4, is the pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, default 4'b1011, width PAT_W, is the target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1; 1 means overlapping matches are detected, 0 means non-overlapping only.
REQ-004 Parameter CNT_W, default 8, is the match-counter width; legal range 1..16.
REQ-005 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, is the asynchronous active-low reset.
REQ-007 Port en, input, 1, is the sample qualifier; x is consumed only in cycles with en=1.
REQ-008 Port clr, input, 1, is the synchronous clear of the FSM and the counter.
REQ-009 Port x, input, 1, is the serial data bit.
REQ-010 Port y, output, 1, is the Moore match flag, decoded from the state register only.
REQ-011 Port match_cnt, output, CNT_W, is the saturating count of detected matches.
REQ-012 Port state_o, output, 4, is the current state index (0..PAT_W), zero-extended.

Function
REQ-013 FSM states are S0..S_PAT_W; Sk means the last k consumed bits equal PATTERN[PAT_W-1 : PAT_W-k].
REQ-014 From Sk with k<PAT_W and en=1, next state is the longest j such that the consumed bits ending in x equal the first j pattern bits (KMP failure rule).
REQ-015 From S_PAT_W with OVERLAP=1, next state applies the REQ-014 rule to the full matched pattern followed by x.
REQ-016 From S_PAT_W with OVERLAP=0, next state is computed as if from S0 (S1 if x==PATTERN[PAT_W-1], else S0).
REQ-017 The transition table is fixed at elaboration from PATTERN; no runtime pattern load.
REQ-018 With en=0 the state holds and x is ignored.
REQ-019 y=1 exactly while state==S_PAT_W; y rises on the clock edge that consumes the final pattern bit, so latency is one clock.
REQ-020 y stays high for multiple cycles if en=0 holds the state at S_PAT_W.
REQ-021 match_cnt increments by 1 on each transition into S_PAT_W, including S_PAT_W to S_PAT_W when overlap allows it.
REQ-022 match_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-023 clr=1 forces state S0 and match_cnt 0 at the next edge, overriding en and x; a match completing in that cycle is not counted.
REQ-024 y and state_o are glitch-free registered/decoded outputs with no combinational path from x, en or clr.

Reset
REQ-025 rst=0 asynchronously forces state S0, y=0, match_cnt=0 and state_o=0, regardless of clk.
REQ-026 Reset asserted mid-sequence discards partial-match progress; detection restarts from S0 after release.
REQ-027 The first edge after rst deasserts is a normal functional edge.

Structure
REQ-028 The shared package holds the state-index width constant (4) and the elaboration-time function computing the next-state table from PATTERN, PAT_W and OVERLAP.
REQ-029 One sub-module, seq_match_counter, implements the CNT_W saturating counter with synchronous clear and increment.
REQ-030 The FSM uses one registered state vector, one combinational next-state block and a decoded y.

Verification
REQ-031 PAT_W=4, PATTERN=1011, OVERLAP=1, en=1, x=1,0,1,1,0,1,1 -> y high after the 4th and 7th bits; match_cnt=2.
REQ-032 Same stream with OVERLAP=0 -> y high only after the 4th bit; match_cnt=1; state S1 at end.
REQ-033 x=1,0,1 then en=0 for 3 cycles, then en=1, x=1 -> state holds S3 during the gap; y rises after the 4th consumed bit.
REQ-034 CNT_W=2, OVERLAP=0, stream 1011 repeated 5 times -> match_cnt reaches 3 and holds at 3.
REQ-035 x=1,0,1 with rst pulled low asynchronously between edges, then release and x=1 -> immediate S0, y=0, cnt=0; the trailing 1 gives S1 and no match.
REQ-036 clr=1 on the edge consuming the final 1 of 1011 -> state S0, y=0, match_cnt=0.

Source files
------------

// File: rtl/moore_seq_detector_pkg.sv
// Shared constants, state encoding and the next-state table builder
// for the Moore sequence detector.
package moore_seq_detector_pkg;

    // Width of the state index; fits S0..S8 for patterns up to 8 bits.
    localparam int STATE_W    = 4;
    localparam int MAX_STATES = 9;
    // One 4-bit entry per (state, input bit) pair.
    localparam int NS_TABLE_W = MAX_STATES * 2 * STATE_W;

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_e;

    // Builds the full transition table at elaboration time. Entry for
    // (k, b) sits at bit offset (k*2+b)*4. The consumed history for state
    // Sk is the first k pattern bits; appending b and taking the longest
    // suffix that is also a pattern prefix gives the KMP next state. From
    // the full-match state without overlap the history is dropped, so only
    // the new bit is considered.
    function automatic logic [NS_TABLE_W-1:0] build_ns_table(
        input logic [7:0] pattern,
        input int         pat_w,
        input int         overlap
    );
        logic [NS_TABLE_W-1:0] tbl;
        logic [8:0]            seq;
        int                    len;
        int                    best;
        logic                  ok;
        tbl = '0;
        for (int k = 0; k < MAX_STATES; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (k <= pat_w) begin
                    seq = '0;
                    if ((k == pat_w) && (overlap == 0)) begin
                        len = 1;
                    end else begin
                        len = k + 1;
                    end
                    // seq[i] is the i-th consumed bit, oldest first
                    for (int i = 0; i < 8; i++) begin
                        if (i < len - 1) begin
                            seq[i] = pattern[pat_w-1-i];
                        end
                    end
                    seq[len-1] = b[0];
                    best = 0;
                    for (int j = 1; j <= 8; j++) begin
                        if ((j <= pat_w) && (j <= len)) begin
                            ok = 1'b1;
                            for (int i = 0; i < 8; i++) begin
                                if (i < j) begin
                                    if (seq[len-j+i] != pattern[pat_w-1-i]) begin
                                        ok = 1'b0;
                                    end
                                end
                            end
                            if (ok) begin
                                best = j;
                            end
                        end
                    end
                    tbl[(k*2+b)*STATE_W +: STATE_W] = best[3:0];
                end
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/moore_seq_detector_seq_match_counter.sv
// Saturating match counter with synchronous clear and increment.
module seq_match_counter
    import moore_seq_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count matches; clear wins over increment, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/moore_seq_detector.sv
// Moore FSM serial pattern detector with a saturating match counter.
// The transition table is derived from PATTERN at elaboration time.
module moore_seq_detector
    import moore_seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [3:0]       state_o
);

    localparam logic [7:0]            PAT_EXT  = 8'(PATTERN);
    localparam logic [NS_TABLE_W-1:0] NS_TABLE = build_ns_table(PAT_EXT, PAT_W, OVERLAP);
    localparam state_e                S_FULL   = state_e'(4'(PAT_W));

    state_e state_r;
    state_e next_s;
    logic   inc_s;

    // State register; only reset, clear or a qualified sample moves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S0;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state lookup and match-event detection for the counter.
    always_comb begin
        next_s = state_r;
        inc_s  = 1'b0;
        if (clr) begin
            next_s = S0;
            inc_s  = 1'b0;
        end else if (en) begin
            next_s = state_e'(NS_TABLE[{state_r, x, 2'b00} +: STATE_W]);
            inc_s  = (next_s == S_FULL);
        end else begin
            next_s = state_r;
            inc_s  = 1'b0;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_s),
        .cnt (match_cnt)
    );

    // Outputs decode straight from the state register, so they never see x/en/clr.
    assign y       = (state_r == S_FULL);
    assign state_o = state_r;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed self-checking bench: three detector instances (overlap,
// non-overlap, non-overlap with 2-bit counter) share one input stream.
module tb_moore_seq_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       x;

    logic       y_ov, y_nov, y_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat;
    logic [3:0] st_ov, st_nov, st_sat;

    int n_checks;
    int n_fail;

    typedef struct {
        logic en;
        logic clr;
        logic x;
        int   s_ov;
        int   c_ov;
        int   s_nov;
        int   c_nov;
    } vec_t;

    vec_t tbl [10];

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
        .y(y_ov), .match_cnt(cnt_ov), .state_o(st_ov)
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_nov (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
        .y(y_nov), .match_cnt(cnt_nov), .state_o(st_nov)
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
        .y(y_sat), .match_cnt(cnt_sat), .state_o(st_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s_ov, input int c_ov,
                           input int s_nov, input int c_nov);
        int c_sat;
        c_sat = (c_nov > 3) ? 3 : c_nov;
        chk({tag, " ov state"},  16'(st_ov),   16'(s_ov));
        chk({tag, " ov y"},      16'(y_ov),    (s_ov == 4) ? 16'd1 : 16'd0);
        chk({tag, " ov cnt"},    16'(cnt_ov),  16'(c_ov));
        chk({tag, " nov state"}, 16'(st_nov),  16'(s_nov));
        chk({tag, " nov y"},     16'(y_nov),   (s_nov == 4) ? 16'd1 : 16'd0);
        chk({tag, " nov cnt"},   16'(cnt_nov), 16'(c_nov));
        chk({tag, " sat state"}, 16'(st_sat),  16'(s_nov));
        chk({tag, " sat cnt"},   16'(cnt_sat), 16'(c_sat));
    endtask

    // Drive inputs on the falling edge, sample just after the rising edge.
    task automatic step(input logic e, input logic c, input logic xi);
        @(negedge clk);
        en  = e;
        clr = c;
        x   = xi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        n_checks = 0;
        n_fail   = 0;
        pat      = 4'b1011;

        // stream 1,0,1,1,0,1,1 then hold with en=0, then clear
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1, 0, 1, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 0, 2, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 3, 0, 3, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4, 1, 4, 1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2, 1, 0, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 3, 1, 1, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 4, 2, 1, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4, 2, 1, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 4, 2, 1, 1};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};

        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        x   = 1'b0;
        #2 rst = 1'b0;
        #2;
        chk_all("reset", 0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].x);
            chk_all($sformatf("vec%0d", i), tbl[i].s_ov, tbl[i].c_ov, tbl[i].s_nov, tbl[i].c_nov);
        end

        // gap with en=0 holds S3, then the final bit completes the match
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("gap pre", 3, 0, 3, 0);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, g[0] ? 1'b0 : 1'b1);
            chk_all($sformatf("gap%0d", g), 3, 0, 3, 0);
        end
        step(1'b1, 1'b0, 1'b1);
        chk_all("gap post", 4, 1, 4, 1);

        // 1011 five times: 8-bit counters reach 5, 2-bit counter sticks at 3
        step(1'b1, 1'b1, 1'b0);
        chk_all("sat clr", 0, 0, 0, 0);
        for (int r = 1; r <= 5; r++) begin
            for (int b = 3; b >= 0; b--) begin
                step(1'b1, 1'b0, pat[b]);
            end
            chk_all($sformatf("sat rep%0d", r), 4, r, 4, r);
        end

        // asynchronous reset between edges discards partial progress
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("arst pre", 3, 5, 3, 5);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk_all("arst mid", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        x   = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst post", 1, 0, 1, 0);

        // clear on the edge that would complete 1011
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("clr pre", 3, 0, 3, 0);
        step(1'b1, 1'b1, 1'b1);
        chk_all("clr hit", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("clr after", 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
